gen_window_acc: RTL and testbench

Downstream consumer of the `gen` arithmetic stage. Accepts the stage's 9-bit unsigned results one per handshake and accumulates them over a window of `2**WIN_LOG2` samples. At window close it presents the sum, minimum, maximum and sample count as a single registered result record. The result is held under valid/ready backpressure until taken. A `flush` input closes a partial window early.

---
 rtl/gen_window_acc.sv | 124 ++++++++++++
 tb/tb_gen_window_acc.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_window_acc.sv
// gen_window_acc: windowed accumulator for the 9-bit results of the gen stage.
//
// Accepts one unsigned sample per in_valid/in_ready handshake and gathers sum, min, max
// and count over a window of 2**WIN_LOG2 samples. When the window fills, or when flush
// closes a partial window, the result record is registered on out_* and held under
// out_valid/out_ready backpressure. No samples are accepted while a record is held.
//
// Ports:
//   clk, rst            single rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   sample handshake; in_data is the unsigned sample
//   flush               close the current (non-empty) window after this cycle's accept
//   out_valid/out_ready record handshake
//   out_sum/min/max/cnt registered window record
//   out_avg             out_sum >> WIN_LOG2, only when GEN_WACC_AVG_EN is defined
//
// Optional feature macro: GEN_WACC_AVG_EN.
module gen_window_acc #(
  parameter int unsigned DW       = 9,
  parameter int unsigned WIN_LOG2 = 3,
  parameter int unsigned SW       = DW + WIN_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SW-1:0]     out_sum,
  output logic [DW-1:0]     out_min,
  output logic [DW-1:0]     out_max,
  output logic [WIN_LOG2:0] out_cnt
`ifdef GEN_WACC_AVG_EN
  ,
  output logic [DW-1:0]     out_avg
`endif
);

  localparam int unsigned CW = WIN_LOG2 + 1;
  localparam logic [CW-1:0] WinLen = CW'(1 << WIN_LOG2);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e        state_q;
  logic [SW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] mn_q, mn_d;
  logic [DW-1:0] mx_q, mx_d;
  logic          accept;
  logic          close;

  // Post-accept values: a closing window includes the sample accepted on the same edge.
  always_comb begin
    in_ready = (state_q == StAccum) && !rst;
    accept   = in_valid && in_ready;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mn_d     = mn_q;
    mx_d     = mx_q;
    if (accept) begin
      acc_d = acc_q + SW'(in_data);
      cnt_d = cnt_q + CW'(1);
      if (in_data < mn_q) mn_d = in_data;
      if (in_data > mx_q) mx_d = in_data;
    end
    // An empty window never closes, so a flush with nothing accepted is a no-op.
    close = (state_q == StAccum) &&
            ((accept && (cnt_d == WinLen)) || (flush && (cnt_d != '0)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StAccum;
      acc_q     <= '0;
      cnt_q     <= '0;
      mn_q      <= '1;
      mx_q      <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_min   <= '0;
      out_max   <= '0;
      out_cnt   <= '0;
`ifdef GEN_WACC_AVG_EN
      out_avg   <= '0;
`endif
    end else begin
      case (state_q)
        StAccum: begin
          if (close) begin
            out_valid <= 1'b1;
            out_sum   <= acc_d;
            out_min   <= mn_d;
            out_max   <= mx_d;
            out_cnt   <= cnt_d;
`ifdef GEN_WACC_AVG_EN
            // Divides by the full window length even for a partial flush.
            out_avg   <= DW'(acc_d >> WIN_LOG2);
`endif
            state_q   <= StHold;
            acc_q     <= '0;
            cnt_q     <= '0;
            mn_q      <= '1;
            mx_q      <= '0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            mn_q  <= mn_d;
            mx_q  <= mx_d;
          end
        end
        StHold: begin
          // Record data stay put after the handshake; only out_valid drops.
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StAccum;
          end
        end
        default: state_q <= StAccum;
      endcase
    end
  end

endmodule

// File: tb/tb_gen_window_acc.sv
module tb_gen_window_acc;

  localparam int DW  = 9;
  localparam int WL  = 3;
  localparam int SW  = DW + WL;
  localparam int WIN = 1 << WL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [SW-1:0] out_sum;
  logic [DW-1:0] out_min;
  logic [DW-1:0] out_max;
  logic [WL:0]   out_cnt;
`ifdef GEN_WACC_AVG_EN
  logic [DW-1:0] out_avg;
`endif

  gen_window_acc #(.DW(DW), .WIN_LOG2(WL), .SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_min   (out_min),
    .out_max   (out_max),
    .out_cnt   (out_cnt)
`ifdef GEN_WACC_AVG_EN
    ,
    .out_avg   (out_avg)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int sum;
    int mn;
    int mx;
    int cnt;
  } rec_t;

  int   checks = 0;
  int   errors = 0;
  rec_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Reference model: a plain list of the samples in the open window plus a "record held" flag.
  int  win[$];
  bit  hold = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready_in_reset", 32'(in_ready), 32'd0);
      win.delete();
      hold = 1'b0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!hold));
      if (!hold) begin
        if (in_valid) win.push_back(int'(in_data));
        if (win.size() == WIN || (flush && win.size() > 0)) begin
          rec_t r;
          r.sum = 0;
          r.mn  = 1 << 30;
          r.mx  = -1;
          foreach (win[i]) begin
            r.sum += win[i];
            if (win[i] < r.mn) r.mn = win[i];
            if (win[i] > r.mx) r.mx = win[i];
          end
          r.cnt = win.size();
          exp_q.push_back(r);
          win.delete();
          hold = 1'b1;
        end
      end else if (out_ready) begin
        hold = 1'b0;
      end
    end
  end

  // Monitor: pops one expected record per presented record, then watches it stay stable.
  bit            seen = 1'b0;
  bit            took_prev = 1'b0;
  bit            rst_prev = 1'b0;
  logic [SW-1:0] h_sum;
  logic [DW-1:0] h_min, h_max;
  logic [WL:0]   h_cnt;

  always @(negedge clk) begin
    if (rst_prev) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_sum", 32'(out_sum), 32'd0);
      chk("rst_out_min", 32'(out_min), 32'd0);
      chk("rst_out_max", 32'(out_max), 32'd0);
      chk("rst_out_cnt", 32'(out_cnt), 32'd0);
`ifdef GEN_WACC_AVG_EN
      chk("rst_out_avg", 32'(out_avg), 32'd0);
`endif
    end
    if (took_prev) chk("valid_drop_after_take", 32'(out_valid), 32'd0);
    if (!rst && out_valid === 1'b1) begin
      if (!seen) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_record", 32'd1, 32'd0);
        end else begin
          rec_t e;
          e = exp_q.pop_front();
          chk("out_sum", 32'(out_sum), 32'(e.sum));
          chk("out_min", 32'(out_min), 32'(e.mn));
          chk("out_max", 32'(out_max), 32'(e.mx));
          chk("out_cnt", 32'(out_cnt), 32'(e.cnt));
`ifdef GEN_WACC_AVG_EN
          chk("out_avg", 32'(out_avg), 32'(e.sum / WIN));
`endif
        end
        h_sum = out_sum;
        h_min = out_min;
        h_max = out_max;
        h_cnt = out_cnt;
        seen  = 1'b1;
      end else begin
        chk("hold_sum_stable", 32'(out_sum), 32'(h_sum));
        chk("hold_min_stable", 32'(out_min), 32'(h_min));
        chk("hold_max_stable", 32'(out_max), 32'(h_max));
        chk("hold_cnt_stable", 32'(out_cnt), 32'(h_cnt));
      end
    end
    took_prev = !rst && out_valid === 1'b1 && out_ready;
    if (took_prev || rst) seen = 1'b0;
    rst_prev = rst;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds the sample until the DUT takes it; in_ready is used for flow control only.
  task automatic send(input int d, input bit f);
    int t;
    bit took;
    t        = 0;
    in_valid = 1'b1;
    in_data  = DW'(d);
    flush    = f;
    do begin
      took = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!took && t < 64);
    if (!took) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=stalled required=accepted");
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    idle(2);
    rst = 1'b0;
    idle(1);

    // 1..8 back-to-back
    for (int i = 1; i <= 8; i++) send(i, 1'b0);
    idle(2);

    // Partial window closed by flush on the last sample
    send(10, 1'b0);
    send(20, 1'b0);
    send(30, 1'b1);
    idle(2);

    // Maximum values: sum must not overflow
    for (int i = 0; i < 8; i++) send(511, 1'b0);
    idle(2);

    // Backpressure with a sample waiting
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(40 + i, 1'b0);
    in_valid = 1'b1;
    in_data  = DW'(99);
    idle(5);
    flush = 1'b1;  // ignored while holding
    idle(1);
    flush = 1'b0;
    out_ready = 1'b1;
    send(99, 1'b0);
    for (int i = 0; i < 7; i++) send(3 * i, 1'b0);
    idle(2);

    // Flush with an empty window
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    idle(3);

    // Reset mid-window
    for (int i = 0; i < 5; i++) send(100 + i, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) send(2, 1'b0);
    idle(2);

    // Random traffic
    repeat (600) begin
      in_valid  = $urandom_range(0, 3) != 0;
      case ($urandom_range(0, 3))
        0:       in_data = '0;
        1:       in_data = '1;
        default: in_data = DW'($urandom_range(0, 511));
      endcase
      flush     = $urandom_range(0, 9) == 0;
      out_ready = $urandom_range(0, 3) != 0;
      rst       = $urandom_range(0, 249) == 0;
      idle(1);
    end

    in_valid  = 1'b0;
    flush     = 1'b0;
    rst       = 1'b0;
    out_ready = 1'b1;
    idle(6);
    chk("records_outstanding", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
